ctr_record_sequencer: RTL and testbench



---
 rtl/ctr_record_sequencer_pkg.sv | 20 ++
 rtl/ctr_compact_fifo.sv | 93 +++++++++
 rtl/ctr_record_sequencer.sv | 145 ++++++++++++++
 tb/tb_ctr_record_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctr_record_sequencer_pkg.sv
// Shared types for the CTR record sequencer: record payload and FSM states.
package ctr_record_sequencer_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned CtrTypeW = 4;

  typedef logic [CtrTypeW-1:0] ctr_type_t;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } ctr_seq_state_e;

  // One control-transfer record as staged and written to the buffer.
  typedef struct packed {
    logic [XLEN-1:0] source;
    ctr_type_t       ctype;
  } ctr_record_t;

endpackage

// File: rtl/ctr_compact_fifo.sv
// Multi-push, single-pop circular FIFO. Valid push lanes are compacted in
// ascending lane order; lanes beyond the free space are dropped and flagged.
//   clk_i, rstn_i   clock, async active-low reset
//   flush_i         empty the FIFO (no pushes that cycle)
//   push_valid_i    per-lane push request
//   push_data_i     per-lane record
//   pop_i           remove head (caller guarantees non-empty)
//   head_o          record at head
//   empty_o         FIFO empty
//   count_o         occupied entries
//   dropped_c       a valid lane found no space this cycle
module ctr_compact_fifo
  import ctr_record_sequencer_pkg::*;
#(
  parameter int unsigned NrPush = 2,
  parameter int unsigned Depth  = 4
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          flush_i,
  input  logic        [NrPush-1:0]      push_valid_i,
  input  ctr_record_t [NrPush-1:0]      push_data_i,
  input  logic                          pop_i,
  output ctr_record_t                   head_o,
  output logic                          empty_o,
  output logic [$clog2(Depth+1)-1:0]    count_o,
  output logic                          dropped_c
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  ctr_record_t     mem_q   [Depth];
  ctr_record_t     wr_data [Depth];
  logic [Depth-1:0] wr_en;
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  int unsigned     rank, free, slot, tail_sum;

  // Lane k lands at tail + (number of accepted lanes below k), wrapping.
  always_comb begin
    wr_en     = '0;
    for (int unsigned i = 0; i < Depth; i++) wr_data[i] = push_data_i[0];
    dropped_c = 1'b0;
    free      = Depth - 32'(count_q);
    rank      = 0;
    slot      = 0;
    for (int unsigned k = 0; k < NrPush; k++) begin
      if (push_valid_i[k]) begin
        if (rank < free) begin
          slot = 32'(tail_q) + rank;
          if (slot >= Depth) slot = slot - Depth;
          wr_en[PtrW'(slot)]   = 1'b1;
          wr_data[PtrW'(slot)] = push_data_i[k];
          rank = rank + 1;
        end else begin
          dropped_c = 1'b1;
        end
      end
    end
    tail_sum = 32'(tail_q) + rank;
    if (tail_sum >= Depth) tail_sum = tail_sum - Depth;
    tail_d  = PtrW'(tail_sum);
    head_d  = head_q;
    if (pop_i) head_d = (head_q == PtrW'(Depth - 1)) ? '0 : head_q + PtrW'(1);
    count_d = count_q + CntW'(rank) - CntW'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < Depth; i++) begin
        if (wr_en[i]) mem_q[i] <= wr_data[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[head_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/ctr_record_sequencer.sv
// Sequences commit-stage control-transfer records into the single-port CTR
// record buffer: compacting staging FIFO, wrapping write pointer, freeze,
// back-pressure, sticky overflow and the multi-cycle clear sweep.
//   clk_i, rstn_i        clock, async active-low reset
//   ctr_source_i/type_i  per-port record payload; ctr_valid_i per-port valid
//   ctr_ready_o          commit may present a full set of records
//   enable_i, freeze_i   recording enable; stop draining
//   clear_i              flush and sweep the buffer
//   rec_*                record buffer write port (combinational)
//   wr_ptr_o             next write index
//   busy_o, overflow_o   sweep active; sticky record-dropped flag
module ctr_record_sequencer
  import ctr_record_sequencer_pkg::*;
#(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned FifoDepth     = 4,
  parameter int unsigned CtrDepth      = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic [NrCommitPorts-1:0][XLEN-1:0]   ctr_source_i,
  input  ctr_type_t [NrCommitPorts-1:0]        ctr_type_i,
  input  logic [NrCommitPorts-1:0]             ctr_valid_i,
  output logic                                 ctr_ready_o,
  input  logic                                 enable_i,
  input  logic                                 freeze_i,
  input  logic                                 clear_i,
  output logic                                 rec_we_o,
  output logic [$clog2(CtrDepth)-1:0]          rec_idx_o,
  output logic                                 rec_valid_o,
  output logic [XLEN-1:0]                      rec_source_o,
  output ctr_type_t                            rec_type_o,
  output logic [$clog2(CtrDepth)-1:0]          wr_ptr_o,
  output logic                                 busy_o,
  output logic                                 overflow_o
);

  localparam int unsigned IdxW = $clog2(CtrDepth);
  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  ctr_seq_state_e state_q, state_d;
  logic [IdxW-1:0] wr_ptr_q, wr_ptr_d, sweep_q, sweep_d;
  logic            overflow_q, overflow_d;
  logic            push_en, pop;
  logic [NrCommitPorts-1:0] push_valid;
  ctr_record_t [NrCommitPorts-1:0] push_data;
  ctr_record_t     fifo_head;
  logic            fifo_empty, fifo_dropped;
  logic [CntW-1:0] fifo_count;

  // Inputs only enter the FIFO while running and not clearing.
  assign push_en    = enable_i && !clear_i && (state_q == RUN);
  assign push_valid = ctr_valid_i & {NrCommitPorts{push_en}};

  always_comb begin
    for (int unsigned k = 0; k < NrCommitPorts; k++) begin
      push_data[k].source = ctr_source_i[k];
      push_data[k].ctype  = ctr_type_i[k];
    end
  end

  ctr_compact_fifo #(
    .NrPush (NrCommitPorts),
    .Depth  (FifoDepth)
  ) u_fifo (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .flush_i      (clear_i),
    .push_valid_i (push_valid),
    .push_data_i  (push_data),
    .pop_i        (pop),
    .head_o       (fifo_head),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count),
    .dropped_c    (fifo_dropped)
  );

  // Ready only when a full set of ports fits; a same-cycle pop is not credited.
  assign ctr_ready_o = (state_q == RUN) &&
                       ((FifoDepth - 32'(fifo_count)) >= NrCommitPorts);

  // Next-state and write-port logic.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    sweep_d      = sweep_q;
    overflow_d   = overflow_q;
    pop          = 1'b0;
    rec_we_o     = 1'b0;
    rec_idx_o    = wr_ptr_q;
    rec_valid_o  = 1'b0;
    rec_source_o = '0;
    rec_type_o   = '0;
    busy_o       = 1'b0;
    case (state_q)
      RUN: begin
        if (!fifo_empty && !freeze_i && !clear_i) begin
          pop          = 1'b1;
          rec_we_o     = 1'b1;
          rec_valid_o  = 1'b1;
          rec_source_o = fifo_head.source;
          rec_type_o   = fifo_head.ctype;
          wr_ptr_d     = wr_ptr_q + IdxW'(1);
        end
        if (fifo_dropped) overflow_d = 1'b1;
      end
      CLEAR: begin
        busy_o    = 1'b1;
        rec_we_o  = 1'b1;
        rec_idx_o = sweep_q;
        if (sweep_q == IdxW'(CtrDepth - 1)) begin
          state_d  = RUN;
          wr_ptr_d = '0;
        end else begin
          sweep_d = sweep_q + IdxW'(1);
        end
      end
      default: state_d = RUN;
    endcase
    // Clear wins from any state and (re)starts the sweep at index 0.
    if (clear_i) begin
      state_d    = CLEAR;
      sweep_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= RUN;
      wr_ptr_q   <= '0;
      sweep_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      sweep_q    <= sweep_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_ptr_o   = wr_ptr_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_ctr_record_sequencer.sv
// Directed self-checking bench for ctr_record_sequencer (2 ports, FIFO 4, buffer 16).
module tb_ctr_record_sequencer;
  import ctr_record_sequencer_pkg::*;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [1:0][XLEN-1:0]  ctr_source;
  ctr_type_t [1:0]       ctr_type;
  logic [1:0]            ctr_valid;
  logic                  ctr_ready;
  logic                  enable, freeze, clear;
  logic                  rec_we, rec_valid, busy, overflow;
  logic [3:0]            rec_idx, wr_ptr;
  logic [XLEN-1:0]       rec_source;
  ctr_type_t             rec_type;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ctr_record_sequencer #(
    .NrCommitPorts (2),
    .FifoDepth     (4),
    .CtrDepth      (16)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .ctr_source_i (ctr_source),
    .ctr_type_i   (ctr_type),
    .ctr_valid_i  (ctr_valid),
    .ctr_ready_o  (ctr_ready),
    .enable_i     (enable),
    .freeze_i     (freeze),
    .clear_i      (clear),
    .rec_we_o     (rec_we),
    .rec_idx_o    (rec_idx),
    .rec_valid_o  (rec_valid),
    .rec_source_o (rec_source),
    .rec_type_o   (rec_type),
    .wr_ptr_o     (wr_ptr),
    .busy_o       (busy),
    .overflow_o   (overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [3:0] idx, input logic [63:0] src,
                        input ctr_type_t ty);
    chk({tag, ".we"},    64'(rec_we),     64'd1);
    chk({tag, ".idx"},   64'(rec_idx),    64'(idx));
    chk({tag, ".valid"}, 64'(rec_valid),  64'd1);
    chk({tag, ".src"},   rec_source,      src);
    chk({tag, ".type"},  64'(rec_type),   64'(ty));
  endtask

  task automatic drive(input logic [1:0] v, input logic [63:0] s0, input ctr_type_t t0,
                       input logic [63:0] s1, input ctr_type_t t1);
    ctr_valid     = v;
    ctr_source[0] = s0;
    ctr_type[0]   = t0;
    ctr_source[1] = s1;
    ctr_type[1]   = t1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; enable = 1'b1; freeze = 1'b0; clear = 1'b0;
    drive(2'b00, 64'd0, 4'd0, 64'd0, 4'd0);
    #12;
    chk("rst.ready",    64'(ctr_ready),  64'd1);
    chk("rst.we",       64'(rec_we),     64'd0);
    chk("rst.idx",      64'(rec_idx),    64'd0);
    chk("rst.valid",    64'(rec_valid),  64'd0);
    chk("rst.src",      rec_source,      64'd0);
    chk("rst.type",     64'(rec_type),   64'd0);
    chk("rst.wrptr",    64'(wr_ptr),     64'd0);
    chk("rst.busy",     64'(busy),       64'd0);
    chk("rst.overflow", 64'(overflow),   64'd0);
    @(negedge clk);
    rstn = 1'b1;
    cyc();

    // Two ports at once: A to idx 0, then B to idx 1.
    drive(2'b11, 64'h1000, 4'd1, 64'h2000, 4'd2);
    #1;
    chk("ab.idle_we", 64'(rec_we),    64'd0);
    chk("ab.ready",   64'(ctr_ready), 64'd1);
    cyc();
    drive(2'b00, 64'd0, 4'd0, 64'd0, 4'd0);
    #1; chk_wr("ab.a", 4'd0, 64'h1000, 4'd1);
    cyc();
    #1; chk_wr("ab.b", 4'd1, 64'h2000, 4'd2);
    cyc();
    // Only port 1 valid: compacted to head, no bubble.
    drive(2'b10, 64'hdead, 4'd9, 64'h3000, 4'd3);
    #1;
    chk("ab.done_we", 64'(rec_we), 64'd0);
    chk("ab.wrptr",   64'(wr_ptr), 64'd2);
    cyc();
    drive(2'b00, 64'd0, 4'd0, 64'd0, 4'd0);
    #1; chk_wr("c", 4'd2, 64'h3000, 4'd3);
    cyc();
    #1;
    chk("c.nobubble", 64'(rec_we), 64'd0);
    chk("c.wrptr",    64'(wr_ptr), 64'd3);
    // Recording disabled: inputs ignored.
    enable = 1'b0;
    drive(2'b11, 64'hbad0, 4'd1, 64'hbad1, 4'd1);
    cyc();
    enable = 1'b1;
    drive(2'b00, 64'd0, 4'd0, 64'd0, 4'd0);
    #1;
    chk("en_off.we",    64'(rec_we), 64'd0);
    chk("en_off.wrptr", 64'(wr_ptr), 64'd3);

    // 14 streamed singles (records 4..17 overall): index wraps 15 -> 0.
    for (int i = 0; i < 15; i++) begin
      if (i < 14) drive(2'b01, 64'h4000 + 64'(i), CtrTypeW'(i), 64'd0, 4'd0);
      else        drive(2'b00, 64'd0, 4'd0, 64'd0, 4'd0);
      #1;
      if (i > 0) chk_wr("wrap", 4'((3 + i - 1) % 16), 64'h4000 + 64'(i - 1), CtrTypeW'(i - 1));
      cyc();
    end
    #1;
    chk("wrap.we",    64'(rec_we), 64'd0);
    chk("wrap.wrptr", 64'(wr_ptr), 64'd1);

    // Freeze: fill FIFO with 2+2, ready drops at count 4, then drain in order.
    freeze = 1'b1;
    drive(2'b11, 64'h5000, 4'd5, 64'h5001, 4'd6);
    #1;
    chk("frz0.we",    64'(rec_we),    64'd0);
    chk("frz0.ready", 64'(ctr_ready), 64'd1);
    cyc();
    drive(2'b11, 64'h5002, 4'd7, 64'h5003, 4'd8);
    #1;
    chk("frz1.we",    64'(rec_we),    64'd0);
    chk("frz1.ready", 64'(ctr_ready), 64'd1);
    cyc();
    drive(2'b00, 64'd0, 4'd0, 64'd0, 4'd0);
    #1;
    chk("frz2.we",    64'(rec_we),    64'd0);
    chk("frz2.ready", 64'(ctr_ready), 64'd0);
    chk("frz2.wrptr", 64'(wr_ptr),    64'd1);
    cyc();
    freeze = 1'b0;
    #1; chk_wr("drain0", 4'd1, 64'h5000, 4'd5); chk("drain0.ready", 64'(ctr_ready), 64'd0);
    cyc();
    #1; chk_wr("drain1", 4'd2, 64'h5001, 4'd6); chk("drain1.ready", 64'(ctr_ready), 64'd0);
    cyc();
    #1; chk_wr("drain2", 4'd3, 64'h5002, 4'd7); chk("drain2.ready", 64'(ctr_ready), 64'd1);
    cyc();
    #1; chk_wr("drain3", 4'd4, 64'h5003, 4'd8); chk("drain3.ready", 64'(ctr_ready), 64'd1);
    cyc();
    #1;
    chk("drain.we",    64'(rec_we), 64'd0);
    chk("drain.wrptr", 64'(wr_ptr), 64'd5);

    // Clear with 3 queued records at wr_ptr 5: sweep 0..15, queued never written.
    freeze = 1'b1;
    drive(2'b11, 64'h6000, 4'd1, 64'h6001, 4'd2);
    cyc();
    drive(2'b01, 64'h6002, 4'd3, 64'd0, 4'd0);
    cyc();
    freeze = 1'b0;
    clear  = 1'b1;
    drive(2'b11, 64'h7000, 4'd4, 64'h7001, 4'd5);
    #1;
    chk("clr.pulse_we",   64'(rec_we), 64'd0);
    chk("clr.pulse_busy", 64'(busy),   64'd0);
    cyc();
    clear  = 1'b0;
    freeze = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("sweep.we",    64'(rec_we),    64'd1);
      chk("sweep.valid", 64'(rec_valid), 64'd0);
      chk("sweep.src",   rec_source,     64'd0);
      chk("sweep.idx",   64'(rec_idx),   64'(i));
      chk("sweep.busy",  64'(busy),      64'd1);
      chk("sweep.ready", 64'(ctr_ready), 64'd0);
      cyc();
    end
    freeze = 1'b0;
    drive(2'b00, 64'd0, 4'd0, 64'd0, 4'd0);
    #1;
    chk("clr.end_busy",  64'(busy),      64'd0);
    chk("clr.end_ready", 64'(ctr_ready), 64'd1);
    chk("clr.end_wrptr", 64'(wr_ptr),    64'd0);
    chk("clr.end_we",    64'(rec_we),    64'd0);
    cyc();
    #1;
    chk("clr.noqueued", 64'(rec_we), 64'd0);

    // Overflow: push into a full FIFO; contents untouched, flag sticky.
    freeze = 1'b1;
    drive(2'b11, 64'h8000, 4'd1, 64'h8001, 4'd2);
    cyc();
    drive(2'b11, 64'h8002, 4'd3, 64'h8003, 4'd4);
    cyc();
    drive(2'b11, 64'h9000, 4'd6, 64'h9001, 4'd7);
    #1;
    chk("ovf.ready",  64'(ctr_ready), 64'd0);
    chk("ovf.before", 64'(overflow),  64'd0);
    cyc();
    drive(2'b00, 64'd0, 4'd0, 64'd0, 4'd0);
    freeze = 1'b0;
    #1;
    chk("ovf.set", 64'(overflow), 64'd1);
    chk_wr("ovf.h0", 4'd0, 64'h8000, 4'd1);
    cyc();
    #1; chk_wr("ovf.h1", 4'd1, 64'h8001, 4'd2);
    cyc();
    #1; chk_wr("ovf.h2", 4'd2, 64'h8002, 4'd3);
    cyc();
    #1; chk_wr("ovf.h3", 4'd3, 64'h8003, 4'd4);
    cyc();
    #1;
    chk("ovf.empty",  64'(rec_we),   64'd0);
    chk("ovf.sticky", 64'(overflow), 64'd1);
    chk("ovf.wrptr",  64'(wr_ptr),   64'd4);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    #1;
    chk("ovf.cleared", 64'(overflow), 64'd0);
    chk("ovf.busy",    64'(busy),     64'd1);
    chk("ovf.idx0",    64'(rec_idx),  64'd0);

    // Clear during sweep restarts at index 0.
    for (int i = 1; i < 5; i++) begin
      cyc();
      #1;
      chk("rs.idx", 64'(rec_idx), 64'(i));
    end
    cyc();
    clear = 1'b1;
    #1;
    chk("rs.cur_idx", 64'(rec_idx), 64'd5);
    chk("rs.cur_we",  64'(rec_we),  64'd1);
    cyc();
    clear = 1'b0;
    #1;
    chk("rs.zero_idx", 64'(rec_idx), 64'd0);
    chk("rs.busy",     64'(busy),    64'd1);
    for (int i = 1; i < 16; i++) begin
      cyc();
      #1;
      chk("rs.sweep_idx", 64'(rec_idx), 64'(i));
    end
    cyc();
    #1;
    chk("rs.end_busy",  64'(busy),      64'd0);
    chk("rs.end_ready", 64'(ctr_ready), 64'd1);

    // Reset mid-sweep returns to reset values immediately.
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    cyc();
    cyc();
    #1;
    chk("mid.busy", 64'(busy), 64'd1);
    #1;
    rstn = 1'b0;
    #1;
    chk("mid.rst_busy",  64'(busy),      64'd0);
    chk("mid.rst_we",    64'(rec_we),    64'd0);
    chk("mid.rst_ready", 64'(ctr_ready), 64'd1);
    chk("mid.rst_idx",   64'(rec_idx),   64'd0);
    chk("mid.rst_wrptr", 64'(wr_ptr),    64'd0);
    #5;
    rstn = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
